// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: clear/set/load/toggle in one
// drive cycle, or ripple-free synchronous counting up/down for N cycles.
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    // state | meaning
    // IDLE  | ready for a command, bank held (j=k=0)
    // DRIVE | one cycle of clear/set/load/toggle pattern on j/k
    // COUNT | one count step per cycle until the latched count is used up
    // DONE  | done pulse, q_in captured into result at the exit edge
    typedef enum logic [1:0] {IDLE, DRIVE, COUNT, DONE} state_t;

    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   remain;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   step;
    logic               is_cnt_cmd;

    assign is_cnt_cmd = (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            data_q   <= '0;
            remain   <= '0;
            result_q <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                remain <= cmd_count;
            end else if (state == COUNT) begin
                remain <= remain - 1'b1;
            end
            if (state == DONE) begin
                result_q <= q_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (is_cnt_cmd) begin
                        state_nx = (cmd_count == '0) ? DONE : COUNT;
                    end else begin
                        state_nx = DRIVE;
                    end
                end
            end
            DRIVE:   state_nx = DONE;
            COUNT:   state_nx = (remain == CNT_W'(1)) ? DONE : COUNT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Synchronous-counter toggle enables: bit i flips when all lower bits
    // are ones (up) or all zeros (down).
    always_comb begin
        step    = '0;
        step[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            step[i] = step[i-1] & ((op_q == OP_CNT_DN) ? ~q_in[i-1] : q_in[i-1]);
        end
    end

    always_comb begin
        j_out = '0;
        k_out = '0;
        case (state)
            DRIVE: begin
                case (op_q)
                    OP_CLEAR:  k_out = '1;
                    OP_SET:    j_out = '1;
                    OP_LOAD: begin
                        j_out = data_q;
                        k_out = ~data_q;
                    end
                    OP_TOGGLE: begin
                        j_out = data_q;
                        k_out = data_q;
                    end
                    default: begin
                        j_out = '0;
                        k_out = '0;
                    end
                endcase
            end
            COUNT: begin
                j_out = step;
                k_out = step;
            end
            default: begin
                j_out = '0;
                k_out = '0;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = (state == DONE) && (op_q == OP_RSVD);
    assign result    = result_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl driving a behavioural 4-bit JK bank.
module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_count;
    logic [3:0] q_bank = 4'h0;
    logic [3:0] j_out, k_out;
    logic       busy, done, err;
    logic [3:0] result;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [3:0] mq = 4'h0;

    typedef struct {
        logic [3:0] res;
        logic       err;
        int         hs;
        int         lat;
    } exp_t;
    exp_t sb[$];

    jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .q_in(q_bank), .j_out(j_out), .k_out(k_out), .busy(busy),
        .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            case ({j_out[i], k_out[i]})
                2'b10:   q_bank[i] <= 1'b1;
                2'b01:   q_bank[i] <= 1'b0;
                2'b11:   q_bank[i] <= ~q_bank[i];
                default: q_bank[i] <= q_bank[i];
            endcase
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_final(input logic [2:0] op, input logic [3:0] d,
                                            input logic [7:0] cnt, input logic [3:0] q);
        case (op)
            3'd1:    return 4'h0;
            3'd2:    return 4'hF;
            3'd3:    return d;
            3'd4:    return q ^ d;
            3'd5:    return q + cnt[3:0];
            3'd6:    return q - cnt[3:0];
            default: return q;
        endcase
    endfunction

    // {j,k} in the first cycle after the handshake
    function automatic logic [7:0] exp_jk(input logic [2:0] op, input logic [3:0] d,
                                         input logic [7:0] cnt, input logic [3:0] q);
        logic [3:0] t;
        case (op)
            3'd1: return {4'h0, 4'hF};
            3'd2: return {4'hF, 4'h0};
            3'd3: return {d, ~d};
            3'd4: return {d, d};
            3'd5: begin
                t = q ^ (q + 4'd1);
                return (cnt == 8'd0) ? 8'h00 : {t, t};
            end
            3'd6: begin
                t = q ^ (q - 4'd1);
                return (cnt == 8'd0) ? 8'h00 : {t, t};
            end
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, input logic [7:0] cnt,
                          input bit hold, output int waited);
        logic [3:0] start, fin, eq;
        logic [7:0] ejk;
        int lat;
        exp_t e;
        start = mq;
        fin   = exp_final(op, d, cnt, start);
        ejk   = exp_jk(op, d, cnt, start);
        lat   = (op == 3'd5 || op == 3'd6) ? ((cnt == 8'd0) ? 1 : int'(cnt) + 1) : 2;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = cnt;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk_val("ready_wait", cmd_ready, 1);
        e.res = fin;
        e.err = (op == 3'd7);
        e.hs  = cyc;
        e.lat = lat;
        sb.push_back(e);
        mq = fin;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk_val("busy", busy, 1);
            chk_val("ready_low", cmd_ready, 0);
            if (op == 3'd5)
                eq = (i <= int'(cnt)) ? start + 4'(i - 1) : fin;
            else if (op == 3'd6)
                eq = (i <= int'(cnt)) ? start - 4'(i - 1) : fin;
            else
                eq = (i == 1) ? start : fin;
            chk_val("q_seq", q_bank, eq);
            if (i == 1) chk_val("jk_first", {j_out, k_out}, ejk);
            if (i == lat) chk_val("jk_done", {j_out, k_out}, 0);
        end
    endtask

    // Scoreboard consumer: done pulse pops an expectation; result checked a cycle later.
    initial begin
        exp_t e;
        bit pend = 1'b0;
        logic [3:0] pres = 4'h0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk_val("result", result, pres);
                pend = 1'b0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk_val("spurious_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk_val("err", err, e.err);
                    chk_val("latency", cyc - e.hs, e.lat);
                    pres = e.res;
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_data = 4'h0;
        cmd_count = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_val("rst_ready", cmd_ready, 1);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_jk", {j_out, k_out}, 0);
        chk_val("rst_result", result, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_err", err, 0);

        do_cmd(3'd3, 4'hA, 8'd0, 0, w);   // LOAD A
        do_cmd(3'd4, 4'h3, 8'd0, 0, w);   // TOGGLE 3 -> 9
        do_cmd(3'd1, 4'h0, 8'd0, 0, w);   // CLEAR
        do_cmd(3'd2, 4'h0, 8'd0, 0, w);   // SET
        do_cmd(3'd3, 4'hE, 8'd0, 0, w);   // LOAD E
        do_cmd(3'd5, 4'h0, 8'd3, 0, w);   // UP 3: E,F,0,1
        do_cmd(3'd1, 4'h0, 8'd0, 0, w);   // CLEAR
        do_cmd(3'd6, 4'h0, 8'd2, 0, w);   // DN 2: F,E
        do_cmd(3'd5, 4'h0, 8'd0, 0, w);   // UP 0
        do_cmd(3'd7, 4'h5, 8'd0, 0, w);   // reserved -> err
        do_cmd(3'd0, 4'h5, 8'd0, 0, w);   // NOP
        do_cmd(3'd6, 4'h0, 8'd20, 0, w);  // DN 20 wraps

        do_cmd(3'd3, 4'h5, 8'd0, 1, w);   // LOAD 5, valid held
        do_cmd(3'd4, 4'hF, 8'd0, 0, w);   // accepted in first IDLE cycle -> A
        chk_val("held_accept_wait", w, 0);

        // Reset during COUNT after 3 steps from A
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_data  = 4'h0;
        cmd_count = 8'd10;
        chk_val("mid_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_val("abort_busy", busy, 0);
        chk_val("abort_ready", cmd_ready, 1);
        chk_val("abort_jk", {j_out, k_out}, 0);
        chk_val("abort_q", q_bank, mq + 4'd3);
        rst = 1'b0;
        mq = mq + 4'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_val("abort_no_done", done, 0);
            chk_val("abort_q_frozen", q_bank, mq);
        end
        chk_val("abort_result", result, 0);

        do_cmd(3'd4, 4'h6, 8'd0, 0, w);   // D ^ 6 -> B
        repeat (3) @(negedge clk);
        chk_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command sequencer for a bank of WIDTH jk_ff cells (one cell per bit) sharing the same clk.
- Accepts one command at a time over a valid/ready handshake: clear, set, load, toggle-mask, or count up/down N steps.
- Drives per-bit J/K vectors into the bank and reads the bank's q vector back.
- Reports completion with a one-cycle done pulse and a captured result.

Parameters:
- WIDTH, 4, number of JK cells in the bank (1..16).
- CNT_W, 8, width of the step count for COUNT commands.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 reserved.
- cmd_data  input  WIDTH  LOAD value or TOGGLE mask.
- cmd_count  input  CNT_W  number of count steps for CNT_UP/CNT_DN.
- q_in  input  WIDTH  q outputs of the JK bank.
- j_out  output  WIDTH  J inputs to the JK bank.
- k_out  output  WIDTH  K inputs to the JK bank.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at command completion.
- err  output  1  one-cycle pulse, coincident with done, for op 7.
- result  output  WIDTH  q_in sampled in DONE; holds until the next DONE.

Behaviour:
- Bank model: each cell updates at the clk edge ending a cycle:
  - J=0,K=0 hold; J=1,K=0 set; J=0,K=1 clear; J=1,K=1 toggle.
- Reset (rst=1 at an edge):
  - state=IDLE, cmd_ready=1 from the following cycle, busy=0, done=0, err=0, result=0.
  - j_out=k_out=0 combinationally while in IDLE.
  - Reset mid-command aborts with no done pulse. The controller never resets the bank.
- j_out/k_out: combinational from the registered state, latched op/data, and q_in. No combinational path from cmd_* to any output.
- States IDLE, DRIVE, COUNT, DONE.
- IDLE:
  - cmd_ready=1, j=k=0.
  - Handshake when cmd_valid&cmd_ready at an edge: latch op/data/count.
  - Next state: CNT_UP/CNT_DN with count>0 -> COUNT; CNT_UP/CNT_DN with count==0 -> DONE; all other ops -> DRIVE.
- DRIVE (exactly 1 cycle), then DONE:
  - NOP and op 7: j=k=0.
  - CLEAR: j=0, k=all-ones.
  - SET: j=all-ones, k=0.
  - LOAD: j=data, k=~data.
  - TOGGLE: j=k=data.
- COUNT (exactly count cycles):
  - remaining counter decrements each cycle; exits to DONE when remaining==1 at an edge.
  - CNT_UP: j[i]=k[i]=AND(q_in[i-1:0]); bit 0 always 1.
  - CNT_DN: j[i]=k[i]=AND(~q_in[i-1:0]); bit 0 always 1.
  - Counting wraps modulo 2^WIDTH (all-ones + 1 -> 0; 0 - 1 -> all-ones).
- DONE (1 cycle):
  - done=1; err=1 only if op==7.
  - result<=q_in at the exit edge; j=k=0; next state IDLE.
- Latency from handshake edge to done high:
  - 2 cycles for DRIVE ops.
  - count+1 cycles for COUNT ops.
  - 1 cycle for count==0.
- cmd_ready=0 from the handshake edge until back in IDLE. A cmd_valid held high is accepted the first IDLE cycle after DONE. Back-to-back throughput is one command per latency+1 cycles.
- Bank reset while controller busy: controller ignores it; COUNT continues from whatever q_in reads.

Test Plan:
- rst=1 for 2 cycles, then release -> cmd_ready=1, busy=0, j_out=k_out=0, result=0, done=0.
- LOAD data=4'hA from q=0 -> j=4'hA, k=4'h5 for one cycle; done 2 cycles after handshake; result=4'hA.
- TOGGLE mask=4'h3 on q=4'hA -> j=k=4'h3; result=4'h9. Then CLEAR -> result=4'h0. Then SET -> result=4'hF.
- CNT_UP count=3 from 4'hE -> q sequence E,F,0,1; done at handshake+4; result=4'h1. CNT_DN count=2 from 0 -> F,E; result=4'hE.
- CNT_UP count=0 -> done next cycle, q unchanged. Op 7 -> done with err=1, q unchanged. cmd_valid held high across DONE -> next command accepted in the first IDLE cycle only.
- rst asserted mid-COUNT (count=10, after 3 steps) -> next cycle IDLE, j=k=0, no done, q frozen at its +3 value.
